// File: rtl/traffic_pkg.sv
// Shared light-bus types and timing defaults for the intersection
// controller and its safety monitor.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2,
        LEFT   = 2'd3
    } traffic_light;

    typedef enum logic [3:0] {
        NS_GREEN   = 4'd0,
        NS_YELLOW  = 4'd1,
        EW_LEFT    = 4'd2,
        EW_YELLOW  = 4'd3,
        EW_GREEN   = 4'd4,
        EW_YELLOW2 = 4'd5,
        NS_LEFT    = 4'd6,
        NS_YELLOW2 = 4'd7,
        ALL_RED    = 4'd8
    } phase_t;

    typedef enum logic [2:0] {
        NONE          = 3'd0,
        CONFLICT      = 3'd1,
        PAIR_MISMATCH = 3'd2,
        SEQUENCE      = 3'd3,
        SHORT         = 3'd4,
        LONG          = 3'd5
    } fault_t;

    // Ring states share their encoding with phase_t
    typedef enum logic [3:0] {
        S_NS_GREEN   = 4'd0,
        S_NS_YELLOW  = 4'd1,
        S_EW_LEFT    = 4'd2,
        S_EW_YELLOW  = 4'd3,
        S_EW_GREEN   = 4'd4,
        S_EW_YELLOW2 = 4'd5,
        S_NS_LEFT    = 4'd6,
        S_NS_YELLOW2 = 4'd7,
        S_SYNC       = 4'd8,
        S_FAULT      = 4'd9
    } state_t;

    localparam int DEF_GREEN_TIME  = 40;
    localparam int DEF_YELLOW_TIME = 5;
    localparam int DEF_LEFT_TIME   = 20;

    function automatic phase_t pattern_of(input phase_t p);
        case (p)
            NS_YELLOW2: pattern_of = NS_YELLOW;
            EW_YELLOW2: pattern_of = EW_YELLOW;
            default:    pattern_of = p;
        endcase
    endfunction

    function automatic phase_t succ_of(input phase_t p);
        case (p)
            NS_GREEN:   succ_of = NS_YELLOW;
            NS_YELLOW:  succ_of = EW_LEFT;
            EW_LEFT:    succ_of = EW_YELLOW;
            EW_YELLOW:  succ_of = EW_GREEN;
            EW_GREEN:   succ_of = EW_YELLOW2;
            EW_YELLOW2: succ_of = NS_LEFT;
            NS_LEFT:    succ_of = NS_YELLOW2;
            default:    succ_of = NS_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_decode.sv
// Combinational decode of the four lamp states into a phase pattern
// plus pairing and cross-axis conflict flags.
module traffic_phase_decode
    import traffic_pkg::*;
(
    input  logic [1:0] i_north,
    input  logic [1:0] i_south,
    input  logic [1:0] i_east,
    input  logic [1:0] i_west,
    output phase_t     o_pattern,
    output logic       o_pair_err,
    output logic       o_conflict
);

    always_comb begin
        o_pair_err = (i_north != i_south) || (i_east != i_west);
        o_conflict = (i_north != RED) && (i_east != RED);
        o_pattern  = ALL_RED;
        if (i_north == RED) begin
            case (i_east)
                GREEN:   o_pattern = EW_GREEN;
                YELLOW:  o_pattern = EW_YELLOW;
                LEFT:    o_pattern = EW_LEFT;
                default: o_pattern = ALL_RED;
            endcase
        end else if (i_east == RED) begin
            case (i_north)
                GREEN:   o_pattern = NS_GREEN;
                YELLOW:  o_pattern = NS_YELLOW;
                LEFT:    o_pattern = NS_LEFT;
                default: o_pattern = ALL_RED;
            endcase
        end
    end

endmodule

// File: rtl/traffic_monitor.sv
// Passive safety checker on the light bus: tracks the phase ring and
// latches the first pairing, conflict, order or dwell violation.
module traffic_monitor
    import traffic_pkg::*;
#(
    parameter int GREEN_TIME  = DEF_GREEN_TIME,
    parameter int YELLOW_TIME = DEF_YELLOW_TIME,
    parameter int LEFT_TIME   = DEF_LEFT_TIME,
    parameter int DWELL_TOL   = 1,
    parameter int FLASH_HALF  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  north,
    input  logic [1:0]  south,
    input  logic [1:0]  east,
    input  logic [1:0]  west,
    input  logic        fault_clr,
    output logic        locked,
    output logic [2:0]  phase,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic        flash,
    output logic [15:0] cycles_done
);

    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

    state_t         r_state;
    logic [7:0]     r_dwell;
    logic           r_first;
    logic [2:0]     r_phase;
    logic           r_locked;
    logic           r_fault;
    fault_t         r_code;
    logic           r_flash;
    logic [FW-1:0]  r_fcnt;
    logic [15:0]    r_cycles;

    phase_t         w_pat;
    logic           w_pair_err;
    logic           w_conflict;
    phase_t         w_cur;
    phase_t         w_succ;
    logic           w_same;
    logic           w_next;
    logic [7:0]     w_exp;
    logic [7:0]     w_lim_hi;
    logic [7:0]     w_lim_lo;
    logic [7:0]     w_dwell_inc;
    state_t         w_state_nxt;
    fault_t         w_code;
    logic           w_go_fault;
    logic [7:0]     w_dwell_nxt;
    logic           w_first_nxt;
    logic [2:0]     w_phase_nxt;
    logic           w_cyc_inc;
    logic           w_lock_nxt;

    traffic_phase_decode u_decode (
        .i_north    (north),
        .i_south    (south),
        .i_east     (east),
        .i_west     (west),
        .o_pattern  (w_pat),
        .o_pair_err (w_pair_err),
        .o_conflict (w_conflict)
    );

    function automatic logic [7:0] exp_of(input phase_t p);
        case (p)
            NS_GREEN, EW_GREEN: exp_of = 8'(GREEN_TIME + 1);
            NS_LEFT, EW_LEFT:   exp_of = 8'(LEFT_TIME + 1);
            default:            exp_of = 8'(YELLOW_TIME + 1);
        endcase
    endfunction

    assign w_cur       = phase_t'({1'b0, r_state[2:0]});
    assign w_succ      = succ_of(w_cur);
    assign w_same      = (w_pat == pattern_of(w_cur));
    assign w_next      = (w_pat == pattern_of(w_succ));
    assign w_exp       = exp_of(w_cur);
    assign w_lim_hi    = w_exp + 8'(DWELL_TOL);
    assign w_lim_lo    = w_exp - 8'(DWELL_TOL);
    assign w_dwell_inc = (&r_dwell) ? r_dwell : r_dwell + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_code      = NONE;
        w_dwell_nxt = r_dwell;
        w_first_nxt = r_first;
        w_phase_nxt = r_phase;
        w_cyc_inc   = 1'b0;
        unique case (r_state)
            S_SYNC: begin
                if (w_pair_err) begin
                    w_code = PAIR_MISMATCH;
                end else if (w_conflict) begin
                    w_code = CONFLICT;
                end else if (w_pat == NS_GREEN) begin
                    w_state_nxt = S_NS_GREEN;
                    w_dwell_nxt = 8'd1;
                    w_first_nxt = 1'b1;
                    w_phase_nxt = 3'd0;
                end
            end
            S_FAULT: begin
                // Clear wins over whatever is on the bus this sample
                if (fault_clr) begin
                    w_state_nxt = S_SYNC;
                    w_dwell_nxt = 8'd0;
                    w_first_nxt = 1'b0;
                end
            end
            default: begin
                if (w_pair_err) begin
                    w_code = PAIR_MISMATCH;
                end else if (w_conflict) begin
                    w_code = CONFLICT;
                end else if (w_same) begin
                    w_dwell_nxt = w_dwell_inc;
                    if (w_dwell_inc > w_lim_hi) begin
                        w_code = LONG;
                    end
                end else if (w_next) begin
                    if (!r_first && (r_dwell < w_lim_lo)) begin
                        w_code = SHORT;
                    end else begin
                        w_state_nxt = state_t'(w_succ);
                        w_dwell_nxt = 8'd1;
                        w_first_nxt = 1'b0;
                        w_phase_nxt = w_succ[2:0];
                        w_cyc_inc   = (w_cur == NS_YELLOW2);
                    end
                end else begin
                    w_code = SEQUENCE;
                end
            end
        endcase
        w_go_fault = (w_code != NONE);
        if (w_go_fault) begin
            w_state_nxt = S_FAULT;
        end
    end

    assign w_lock_nxt = (w_state_nxt != S_SYNC) && (w_state_nxt != S_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell  <= 8'd0;
            r_first  <= 1'b0;
            r_phase  <= 3'd0;
            r_locked <= 1'b0;
            r_fault  <= 1'b0;
            r_code   <= NONE;
            r_flash  <= 1'b0;
            r_fcnt   <= '0;
            r_cycles <= 16'd0;
        end else begin
            r_dwell  <= w_dwell_nxt;
            r_first  <= w_first_nxt;
            r_phase  <= w_phase_nxt;
            r_locked <= w_lock_nxt;
            if (w_go_fault) begin
                r_fault <= 1'b1;
                r_code  <= w_code;
                r_flash <= 1'b1;
                r_fcnt  <= '0;
            end else if ((r_state == S_FAULT) && fault_clr) begin
                r_fault <= 1'b0;
                r_code  <= NONE;
                r_flash <= 1'b0;
                r_fcnt  <= '0;
            end else if (r_state == S_FAULT) begin
                if (r_fcnt == FLASH_LAST) begin
                    r_fcnt  <= '0;
                    r_flash <= ~r_flash;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end
            if (w_cyc_inc && (r_cycles != 16'hFFFF)) begin
                r_cycles <= r_cycles + 16'd1;
            end
        end
    end

    assign locked      = r_locked;
    assign phase       = r_phase;
    assign fault       = r_fault;
    assign fault_code  = r_code;
    assign flash       = r_flash;
    assign cycles_done = r_cycles;

endmodule

// File: tb/tb_traffic_monitor.sv
// Scoreboard bench for traffic_monitor: expectations are queued as
// each sample is driven and compared after the sampling edge.
module tb_traffic_monitor;

    localparam logic [1:0] LG = 2'd0;
    localparam logic [1:0] LY = 2'd1;
    localparam logic [1:0] LR = 2'd2;
    localparam logic [1:0] LL = 2'd3;

    typedef enum int {F_LOCK, F_PHASE, F_FAULT, F_CODE, F_FLASH, F_CYC} fld_t;

    typedef struct {
        int    when;
        string tag;
        fld_t  f;
        int    v;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  north;
    logic [1:0]  south;
    logic [1:0]  east;
    logic [1:0]  west;
    logic        fault_clr;
    logic        locked;
    logic [2:0]  phase;
    logic        fault;
    logic [2:0]  fault_code;
    logic        flash;
    logic [15:0] cycles_done;

    exp_t q[$];
    int   cyc;
    int   n_chk;
    int   n_err;

    int         dw[8] = '{41, 6, 21, 6, 41, 6, 21, 6};
    logic [1:0] lns[8] = '{LG, LY, LR, LR, LR, LR, LL, LY};
    logic [1:0] lew[8] = '{LR, LR, LL, LY, LG, LY, LR, LR};

    traffic_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .north       (north),
        .south       (south),
        .east        (east),
        .west        (west),
        .fault_clr   (fault_clr),
        .locked      (locked),
        .phase       (phase),
        .fault       (fault),
        .fault_code  (fault_code),
        .flash       (flash),
        .cycles_done (cycles_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] actual(input fld_t f);
        case (f)
            F_LOCK:  return {31'd0, locked};
            F_PHASE: return {29'd0, phase};
            F_FAULT: return {31'd0, fault};
            F_CODE:  return {29'd0, fault_code};
            F_FLASH: return {31'd0, flash};
            default: return {16'd0, cycles_done};
        endcase
    endfunction

    task automatic sb_push(input string tag, input fld_t f, input int v);
        exp_t e;
        e.when = cyc + 1;
        e.tag  = tag;
        e.f    = f;
        e.v    = v;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].when <= cyc) begin
                e = q.pop_front();
                chk(e.tag, actual(e.f), 32'(e.v));
            end
        end
    end

    task automatic drive1(input logic [1:0] ns, input logic [1:0] ew,
                          input logic clr);
        @(negedge clk);
        north     = ns;
        south     = ns;
        east      = ew;
        west      = ew;
        fault_clr = clr;
    endtask

    task automatic run_phase(input int p, input int n, input string tg);
        for (int i = 0; i < n; i++) begin
            drive1(lns[p], lew[p], 1'b0);
            if (i == 0) begin
                sb_push({tg, "_ph"}, F_PHASE, p);
                sb_push({tg, "_lock"}, F_LOCK, 1);
            end
        end
    endtask

    task automatic clear_with(input logic [1:0] ns, input logic [1:0] ew,
                              input string tg);
        drive1(ns, ew, 1'b1);
        sb_push({tg, "_fault"}, F_FAULT, 0);
        sb_push({tg, "_code"}, F_CODE, 0);
        sb_push({tg, "_lock"}, F_LOCK, 0);
        sb_push({tg, "_flash"}, F_FLASH, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        north     = LR;
        south     = LR;
        east      = LR;
        west      = LR;
        fault_clr = 1'b0;
        #3;
        chk("rst_lock", {31'd0, locked}, 0);
        chk("rst_phase", {29'd0, phase}, 0);
        chk("rst_fault", {31'd0, fault}, 0);
        chk("rst_code", {29'd0, fault_code}, 0);
        chk("rst_flash", {31'd0, flash}, 0);
        chk("rst_cyc", {16'd0, cycles_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // SYNC ignores order: all-red and yellow do not lock or fault
        for (int i = 0; i < 3; i++) begin
            drive1(LR, LR, 1'b0);
            sb_push("sync_allred_lock", F_LOCK, 0);
        end
        drive1(LY, LR, 1'b0);
        sb_push("sync_yel_lock", F_LOCK, 0);
        sb_push("sync_yel_fault", F_FAULT, 0);

        // Three nominal light cycles
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < 8; p++) begin
                run_phase(p, dw[p], $sformatf("nom_c%0d_p%0d", c, p));
                sb_push($sformatf("nom_c%0d_p%0d_nf", c, p), F_FAULT, 0);
            end
            sb_push($sformatf("nom_c%0d_cyc", c), F_CYC, c);
        end
        run_phase(0, 5, "nom_c3_p0");
        sb_push("nom_c3_cyc", F_CYC, 3);

        // Pair mismatch during NS_GREEN, then flasher period
        @(negedge clk);
        north = LG;
        south = LG;
        east  = LR;
        west  = LG;
        sb_push("pair_fault", F_FAULT, 1);
        sb_push("pair_code", F_CODE, 2);
        sb_push("pair_flash0", F_FLASH, 1);
        sb_push("pair_lock", F_LOCK, 0);
        sb_push("pair_phase", F_PHASE, 0);
        for (int k = 1; k <= 16; k++) begin
            drive1(LG, LG, 1'b0);
            if (k == 7)  sb_push("flash_k7", F_FLASH, 1);
            if (k == 8)  sb_push("flash_k8", F_FLASH, 0);
            if (k == 15) sb_push("flash_k15", F_FLASH, 0);
            if (k == 16) begin
                sb_push("flash_k16", F_FLASH, 1);
                sb_push("pair_code_held", F_CODE, 2);
            end
        end

        // Clear, re-lock, then jump NS_GREEN -> EW_GREEN
        clear_with(LY, LR, "clr1");
        drive1(LL, LR, 1'b0);
        sb_push("clr1_nslock", F_LOCK, 0);
        run_phase(0, 5, "relock1");
        drive1(LR, LG, 1'b0);
        sb_push("seq_fault", F_FAULT, 1);
        sb_push("seq_code", F_CODE, 3);
        sb_push("seq_phase", F_PHASE, 0);

        // SHORT: yellow held 4 samples
        clear_with(LR, LR, "clr2");
        run_phase(0, 41, "short_g");
        run_phase(1, 4, "short_y");
        sb_push("short_y4_nf", F_FAULT, 0);
        drive1(LR, LL, 1'b0);
        sb_push("short_fault", F_FAULT, 1);
        sb_push("short_code", F_CODE, 4);

        // Yellow held EXP-TOL samples is still legal
        clear_with(LR, LR, "clr3");
        run_phase(0, 41, "bnd_g");
        run_phase(1, 5, "bnd_y");
        drive1(LR, LL, 1'b0);
        sb_push("bnd_nf", F_FAULT, 0);
        sb_push("bnd_ph", F_PHASE, 2);
        drive1(LG, LR, 1'b0);
        sb_push("seq2_code", F_CODE, 3);

        // LONG: green held 43 samples
        clear_with(LR, LR, "clr4");
        run_phase(0, 42, "long_g");
        sb_push("long_42_nf", F_FAULT, 0);
        drive1(LG, LR, 1'b0);
        sb_push("long_fault", F_FAULT, 1);
        sb_push("long_code", F_CODE, 5);

        // Clear on the same edge as a conflict: clear wins
        clear_with(LG, LG, "clr_conf");
        drive1(LG, LG, 1'b0);
        sb_push("conf_fault", F_FAULT, 1);
        sb_push("conf_code", F_CODE, 1);

        // ALL_RED once locked is an order fault
        clear_with(LR, LR, "clr5");
        run_phase(0, 3, "ar_g");
        drive1(LR, LR, 1'b0);
        sb_push("allred_code", F_CODE, 3);

        // Async reset mid EW_GREEN
        clear_with(LR, LR, "clr6");
        for (int p = 0; p < 4; p++) begin
            run_phase(p, dw[p], $sformatf("pre_rst_p%0d", p));
        end
        run_phase(4, 10, "pre_rst_p4");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_lock", {31'd0, locked}, 0);
        chk("arst_phase", {29'd0, phase}, 0);
        chk("arst_fault", {31'd0, fault}, 0);
        chk("arst_code", {29'd0, fault_code}, 0);
        chk("arst_flash", {31'd0, flash}, 0);
        chk("arst_cyc", {16'd0, cycles_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_phase(0, 2, "post_rst");
        sb_push("post_rst_cyc", F_CYC, 0);

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
